// File: rtl/cr_tlvp2_axis_egress.sv
// AXI4-Stream egress for the TLV reassembly output FIFO: a 2-entry registered skid buffer,
// frame-boundary hold for drain/quiesce, and beat/frame statistics.
module cr_tlvp2_axis_egress #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STRB_W = 8,
    parameter int unsigned USER_W = 2,
    parameter int unsigned ID_W   = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_empty,
    output logic              src_rd,
    input  logic [DATA_W-1:0] src_tdata,
    input  logic [STRB_W-1:0] src_tstrb,
    input  logic [USER_W-1:0] src_tuser,
    input  logic [ID_W-1:0]   src_tid,
    input  logic              src_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [STRB_W-1:0] m_tstrb,
    output logic [USER_W-1:0] m_tuser,
    output logic [ID_W-1:0]   m_tid,
    output logic              m_tlast,
    input  logic              cfg_hold,
    output logic              hold_ack,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_beats,
    output logic [CNT_W-1:0]  stat_frames
);

    localparam int unsigned BEAT_W = DATA_W + STRB_W + USER_W + ID_W + 1;

    typedef enum logic [1:0] {StIdle, StFrame, StHeld} state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [BEAT_W-1:0]   head_q, head_d, skid_q, skid_d, src_beat;
    logic                hold_ack_q, hold_ack_d;
    logic [CNT_W-1:0]    beats_q, beats_d, frames_q, frames_d;
    logic                push, pop;

    assign src_beat = {src_tdata, src_tstrb, src_tuser, src_tid, src_tlast};
    assign {m_tdata, m_tstrb, m_tuser, m_tid, m_tlast} = head_q;
    assign m_tvalid    = (cnt_q != 2'd0);
    assign push        = src_rd;
    assign pop         = m_tvalid & m_tready;
    assign hold_ack    = hold_ack_q;
    assign stat_beats  = beats_q;
    assign stat_frames = frames_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The FSM follows popped beats, so a hold only lands once the source side is between frames.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (push) begin
                    state_d = src_tlast ? StIdle : StFrame;
                end else if (cfg_hold) begin
                    state_d = StHeld;
                end
            end
            StFrame: begin
                if (push && src_tlast) begin
                    state_d = StIdle;
                end
            end
            StHeld: begin
                if (!cfg_hold) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        src_rd = !rst && !src_empty && (cnt_q != 2'd2) && (state_q != StHeld)
                 && !((state_q == StIdle) && cfg_hold);
    end

    // Head always drives m_*; the skid entry only fills when the head is stalled.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        cnt_d  = cnt_q;
        if (pop && (cnt_q == 2'd2)) begin
            head_d = skid_q;
        end else if (push && ((cnt_q == 2'd0) || pop)) begin
            head_d = src_beat;
        end
        if (push && !pop && (cnt_q == 2'd1)) begin
            skid_d = src_beat;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        hold_ack_d = (state_q == StHeld) && (cnt_q == 2'd0);
        beats_d    = beats_q;
        frames_d   = frames_q;
        if (stat_clr) begin
            beats_d  = '0;
            frames_d = '0;
        end else if (pop) begin
            beats_d = beats_q + CNT_W'(1);
            if (m_tlast) begin
                frames_d = frames_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 2'd0;
            head_q     <= '0;
            skid_q     <= '0;
            hold_ack_q <= 1'b0;
            beats_q    <= '0;
            frames_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            hold_ack_q <= hold_ack_d;
            beats_q    <= beats_d;
            frames_q   <= frames_d;
        end
    end

endmodule

// File: tb/tb_cr_tlvp2_axis_egress.sv
// Scoreboard bench for cr_tlvp2_axis_egress: a show-ahead FIFO model feeds the DUT, expected
// beats are queued at load time and a negedge monitor checks every AXI transfer.
module tb_cr_tlvp2_axis_egress;

    localparam int DW = 64;
    localparam int SW = 8;
    localparam int UW = 2;
    localparam int IW = 1;
    localparam int CW = 4;

    typedef logic [75:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_empty, src_rd;
    logic [DW-1:0] src_tdata;
    logic [SW-1:0] src_tstrb;
    logic [UW-1:0] src_tuser;
    logic [IW-1:0] src_tid;
    logic          src_tlast;
    logic          m_tvalid, m_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic [UW-1:0] m_tuser;
    logic [IW-1:0] m_tid;
    logic          m_tlast;
    logic          cfg_hold, hold_ack, stat_clr;
    logic [CW-1:0] stat_beats, stat_frames;

    beat_t         srcq[$];
    beat_t         expq[$];
    int            checks = 0;
    int            passes = 0;
    int            inflight = 0;
    logic          rd_s = 1'b0;
    bit            ready_rand = 1'b0;
    logic [CW-1:0] mb = '0, mf = '0;
    logic          prev_valid = 1'b0, prev_ready = 1'b0;
    beat_t         prev_beat = '0;
    beat_t         cur;

    always #5 clk = ~clk;

    cr_tlvp2_axis_egress #(
        .DATA_W(DW), .STRB_W(SW), .USER_W(UW), .ID_W(IW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .src_empty(src_empty), .src_rd(src_rd),
        .src_tdata(src_tdata), .src_tstrb(src_tstrb), .src_tuser(src_tuser),
        .src_tid(src_tid), .src_tlast(src_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tuser(m_tuser),
        .m_tid(m_tid), .m_tlast(m_tlast),
        .cfg_hold(cfg_hold), .hold_ack(hold_ack),
        .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_frames(stat_frames)
    );

    task automatic chk(input string name, input beat_t act, input beat_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic beat_t mk(input logic [63:0] d, input logic last);
        return {d, d[7:0] ^ 8'hA5, d[1:0], d[2], last};
    endfunction

    task automatic refresh();
        if (srcq.size() == 0) begin
            src_empty = 1'b1;
            {src_tdata, src_tstrb, src_tuser, src_tid, src_tlast} = '0;
        end else begin
            src_empty = 1'b0;
            {src_tdata, src_tstrb, src_tuser, src_tid, src_tlast} = srcq[0];
        end
    endtask

    task automatic push_beat(input logic [63:0] d, input logic last);
        srcq.push_back(mk(d, last));
        expq.push_back(mk(d, last));
        refresh();
    endtask

    // One clock: the FIFO model pops what the DUT popped, then inputs change 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rd_s) begin
            void'(srcq.pop_front());
            inflight++;
        end
        if (ready_rand) m_tready = 1'($urandom_range(0, 1));
        refresh();
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk(name, beat_t'(expq.size()), beat_t'(0));
    endtask

    task automatic chk_stats(input string name, input logic [CW-1:0] b, input logic [CW-1:0] f);
        chk({name, "_beats"}, beat_t'(stat_beats), beat_t'(b));
        chk({name, "_frames"}, beat_t'(stat_frames), beat_t'(f));
        chk({name, "_beats_model"}, beat_t'(stat_beats), beat_t'(mb));
    endtask

    always @(negedge clk) begin
        rd_s = src_rd;
        cur = {m_tdata, m_tstrb, m_tuser, m_tid, m_tlast};
        if (!rst) begin
            chk("rd_while_empty", beat_t'(src_rd & src_empty), beat_t'(0));
            if (prev_valid && !prev_ready) begin
                chk("axi_hold_valid", beat_t'(m_tvalid), beat_t'(1));
                chk("axi_hold_data", cur, prev_beat);
            end
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", cur);
                end else begin
                    chk("beat", cur, expq.pop_front());
                    inflight--;
                end
            end
            if (stat_clr) begin
                mb = '0;
                mf = '0;
            end else if (m_tvalid && m_tready) begin
                mb = mb + 1'b1;
                mf = mf + CW'(m_tlast);
            end
        end
        prev_valid = m_tvalid & !rst;
        prev_ready = m_tready;
        prev_beat  = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_tready = 1'b0;
        cfg_hold = 1'b0;
        stat_clr = 1'b0;
        refresh();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", beat_t'(m_tvalid), beat_t'(0));
        chk("rst_src_rd", beat_t'(src_rd), beat_t'(0));
        chk("rst_hold_ack", beat_t'(hold_ack), beat_t'(0));
        chk("rst_stat_beats", beat_t'(stat_beats), beat_t'(0));
        chk("rst_stat_frames", beat_t'(stat_frames), beat_t'(0));
        chk("rst_tdata", beat_t'(m_tdata), beat_t'(0));
        cyc();

        // Streaming: one beat per clock, first valid one cycle after the pop.
        clear_stats();
        m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) push_beat(64'(i), i == 4);
        @(negedge clk);
        chk("lat_src_rd", beat_t'(src_rd), beat_t'(1));
        chk("lat_tvalid_early", beat_t'(m_tvalid), beat_t'(0));
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_tvalid", beat_t'(m_tvalid), beat_t'(1));
            chk("stream_tdata", beat_t'(m_tdata), beat_t'(i + 1));
            cyc();
        end
        chk_stats("stream", 4'd4, 4'd1);

        // Backpressure: skid fills to two entries, then pops stop.
        clear_stats();
        for (int i = 1; i <= 8; i++) push_beat(64'(i), (i == 4) || (i == 8));
        cyc();
        cyc();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_tvalid", beat_t'(m_tvalid), beat_t'(1));
            chk("bp_tdata", beat_t'(m_tdata), beat_t'(2));
            if (i >= 1) chk("bp_src_rd", beat_t'(src_rd), beat_t'(0));
            cyc();
        end
        m_tready = 1'b1;
        wait_drain(40, "bp_drain");
        chk_stats("bp", 4'd8, 4'd2);

        // Hold raised mid-frame: frame 1 finishes, frame 2 stays in the FIFO.
        clear_stats();
        for (int i = 1; i <= 4; i++) push_beat(64'h10 + 64'(i), i == 4);
        for (int i = 1; i <= 4; i++) push_beat(64'h20 + 64'(i), i == 4);
        cyc();
        cyc();
        cfg_hold = 1'b1;
        for (int n = 0; n < 20 && !hold_ack; n++) cyc();
        chk("hold_ack_seen", beat_t'(hold_ack), beat_t'(1));
        chk("hold_tvalid", beat_t'(m_tvalid), beat_t'(0));
        chk("hold_frame2_unpopped", beat_t'(srcq.size()), beat_t'(4));
        chk("hold_frame1_done", beat_t'(expq.size()), beat_t'(4));
        repeat (3) cyc();
        chk("hold_still_unpopped", beat_t'(srcq.size()), beat_t'(4));
        cfg_hold = 1'b0;
        wait_drain(40, "hold_resume_drain");
        chk("hold_ack_released", beat_t'(hold_ack), beat_t'(0));
        chk_stats("hold", 4'd8, 4'd2);

        // Single-beat frames under random ready.
        clear_stats();
        ready_rand = 1'b1;
        for (int i = 0; i < 10; i++) push_beat(64'h40 + 64'(i), 1'b1);
        wait_drain(300, "single_drain");
        ready_rand = 1'b0;
        m_tready = 1'b1;
        chk_stats("single", 4'd10, 4'd10);

        // Wrap of a 4-bit counter: 17 beats leave 1.
        clear_stats();
        for (int i = 0; i < 17; i++) push_beat(64'h60 + 64'(i), 1'b1);
        wait_drain(60, "wrap_drain");
        chk_stats("wrap", 4'd1, 4'd1);

        // Clear coinciding with a transfer wins.
        for (int i = 1; i <= 3; i++) push_beat(64'h50 + 64'(i), i == 3);
        cyc();
        cyc();
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk_stats("clr_coincident", 4'd0, 4'd0);
        wait_drain(20, "clr_drain");
        chk_stats("clr_after", 4'd1, 4'd1);

        // Asynchronous reset with two beats buffered.
        m_tready = 1'b0;
        for (int i = 1; i <= 4; i++) push_beat(64'h30 + 64'(i), i == 4);
        repeat (3) cyc();
        @(negedge clk);
        chk("pre_rst_full", beat_t'(src_rd), beat_t'(0));
        chk("pre_rst_inflight", beat_t'(inflight), beat_t'(2));
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_tvalid", beat_t'(m_tvalid), beat_t'(0));
        chk("arst_stat_beats", beat_t'(stat_beats), beat_t'(0));
        chk("arst_stat_frames", beat_t'(stat_frames), beat_t'(0));
        chk("arst_tdata", beat_t'(m_tdata), beat_t'(0));
        chk("arst_src_rd", beat_t'(src_rd), beat_t'(0));
        repeat (inflight) void'(expq.pop_front());
        inflight = 0;
        mb = '0;
        mf = '0;
        cyc();
        rst = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        chk("post_rst_pop", beat_t'(src_rd), beat_t'(1));
        wait_drain(20, "post_rst_drain");
        chk_stats("post_rst", 4'd2, 4'd1);

        repeat (3) cyc();
        chk("end_inflight", beat_t'(inflight), beat_t'(0));
        chk("end_src_empty", beat_t'(src_empty), beat_t'(1));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
